// File: rtl/ysyx_23060077_define.sv
// Shared encodings for the AXI read arbiter: FSM states, AXI burst/size/resp
// constants and the default ARID assignments for each requester.
package ysyx_23060077_define;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [3:0] ID_ICACHE_DFLT = 4'd0;
  localparam logic [3:0] ID_LSU_DFLT    = 4'd1;

endpackage

// File: rtl/ysyx_23060077_rr_arbiter2.sv
// Two-way round-robin grant between Icache and LSU. The last-grant register
// only moves when a burst completes, so a held request cannot lose its turn.
module ysyx_23060077_rr_arbiter2 (
  input  logic clock,
  input  logic reset,
  input  logic req_icache,
  input  logic req_lsu,
  input  logic done_valid,
  input  logic done_lsu,
  output logic grant_valid,
  output logic grant_lsu
);

  logic last_lsu_q;

  // Reset to LSU so the first contention goes to the Icache.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_lsu_q <= 1'b1;
    end else if (done_valid) begin
      last_lsu_q <= done_lsu;
    end
  end

  always_comb begin
    grant_valid = req_icache | req_lsu;
    grant_lsu   = req_lsu & (~req_icache | ~last_lsu_q);
  end

endmodule

// File: rtl/ysyx_23060077_axi_rd_arbiter.sv
// Shares one AXI read channel between Icache bursts and single-beat LSU reads,
// one transaction in flight, R beats steered combinationally to the owner.
//
// Handshakes: an AXI transfer happens on a clock edge where valid and ready
// are both high; AR fields stay stable while arvalid waits for arready, and
// rready is asserted only while a granted burst is in its data phase.
module ysyx_23060077_axi_rd_arbiter
  import ysyx_23060077_define::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] ID_ICACHE  = ID_ICACHE_DFLT,
  parameter logic [3:0] ID_LSU     = ID_LSU_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] icache_r_addr_i,
  input  logic [7:0]            icache_r_len_i,
  output logic                  icache_r_ready_o,
  output logic [DATA_WIDTH-1:0] icache_r_data_o,
  output logic                  icache_r_last_o,
  input  logic                  lsu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
  input  logic [2:0]            lsu_r_size_i,
  output logic                  lsu_r_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_r_data_o,
  output logic                  lsu_r_last_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  output logic [ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [7:0]            axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [3:0]            axi_arid_o,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o,
  input  logic [DATA_WIDTH-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic [3:0]            axi_rid_i,
  output logic                  rd_err_o,
  output logic [1:0]            state_dbg_o
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [3:0]            ar_id_q;
  logic                  owner_lsu_q;
  logic                  rd_err_q;

  logic grant_valid;
  logic grant_lsu;
  logic in_data;
  logic beat;
  logic burst_done;
  logic beat_err;

  ysyx_23060077_rr_arbiter2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .req_icache  (icache_r_valid_i),
    .req_lsu     (lsu_r_valid_i),
    .done_valid  (burst_done),
    .done_lsu    (owner_lsu_q),
    .grant_valid (grant_valid),
    .grant_lsu   (grant_lsu)
  );

  // Gating with reset makes every forwarded output drop in the same cycle
  // reset is asserted, not one cycle later.
  always_comb begin
    in_data    = (state_q == ST_DATA) && reset;
    beat       = in_data && axi_rvalid_i;
    burst_done = beat && axi_rlast_i;
    beat_err   = beat && ((axi_rresp_i != AXI_RESP_OKAY) || (axi_rid_i != ar_id_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_valid)    state_d = ST_ADDR;
      ST_ADDR: if (axi_arready_i)  state_d = ST_DATA;
      ST_DATA: if (burst_done)     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      ar_id_q     <= '0;
      owner_lsu_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= beat_err;
      if (state_q == ST_IDLE && grant_valid) begin
        owner_lsu_q <= grant_lsu;
        ar_burst_q  <= AXI_BURST_INCR;
        if (grant_lsu) begin
          ar_addr_q <= lsu_r_addr_i;
          ar_len_q  <= AXI_LEN_SINGLE;
          ar_size_q <= lsu_r_size_i;
          ar_id_q   <= ID_LSU;
        end else begin
          ar_addr_q <= icache_r_addr_i;
          ar_len_q  <= icache_r_len_i;
          ar_size_q <= AXI_SIZE_4B;
          ar_id_q   <= ID_ICACHE;
        end
      end
    end
  end

  always_comb begin
    axi_arvalid_o    = (state_q == ST_ADDR) && reset;
    axi_araddr_o     = ar_addr_q;
    axi_arlen_o      = ar_len_q;
    axi_arsize_o     = ar_size_q;
    axi_arburst_o    = ar_burst_q;
    axi_arid_o       = ar_id_q;
    axi_rready_o     = in_data;

    icache_r_ready_o = beat && !owner_lsu_q;
    icache_r_last_o  = burst_done && !owner_lsu_q;
    icache_r_data_o  = (beat && !owner_lsu_q) ? axi_rdata_i : '0;
    lsu_r_ready_o    = beat && owner_lsu_q;
    lsu_r_last_o     = burst_done && owner_lsu_q;
    lsu_r_data_o     = (beat && owner_lsu_q) ? axi_rdata_i : '0;

    rd_err_o         = rd_err_q;
    state_dbg_o      = state_q;
  end

endmodule

// File: tb/tb_ysyx_23060077_axi_rd_arbiter.sv
// Directed bench for the AXI read arbiter: a vector table of arbitration /
// burst cases plus hand-written sequences for ordering and mid-burst reset.
module tb_ysyx_23060077_axi_rd_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd2;

  logic        clock;
  logic        reset;
  logic        icache_r_valid_i;
  logic [31:0] icache_r_addr_i;
  logic [7:0]  icache_r_len_i;
  logic        icache_r_ready_o;
  logic [31:0] icache_r_data_o;
  logic        icache_r_last_o;
  logic        lsu_r_valid_i;
  logic [31:0] lsu_r_addr_i;
  logic [2:0]  lsu_r_size_i;
  logic        lsu_r_ready_o;
  logic [31:0] lsu_r_data_o;
  logic        lsu_r_last_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic [3:0]  axi_arid_o;
  logic        axi_rvalid_i;
  logic        axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic [3:0]  axi_rid_i;
  logic        rd_err_o;
  logic [1:0]  state_dbg_o;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060077_axi_rd_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .icache_r_valid_i (icache_r_valid_i),
    .icache_r_addr_i  (icache_r_addr_i),
    .icache_r_len_i   (icache_r_len_i),
    .icache_r_ready_o (icache_r_ready_o),
    .icache_r_data_o  (icache_r_data_o),
    .icache_r_last_o  (icache_r_last_o),
    .lsu_r_valid_i    (lsu_r_valid_i),
    .lsu_r_addr_i     (lsu_r_addr_i),
    .lsu_r_size_i     (lsu_r_size_i),
    .lsu_r_ready_o    (lsu_r_ready_o),
    .lsu_r_data_o     (lsu_r_data_o),
    .lsu_r_last_o     (lsu_r_last_o),
    .axi_arvalid_o    (axi_arvalid_o),
    .axi_arready_i    (axi_arready_i),
    .axi_araddr_o     (axi_araddr_o),
    .axi_arlen_o      (axi_arlen_o),
    .axi_arsize_o     (axi_arsize_o),
    .axi_arburst_o    (axi_arburst_o),
    .axi_arid_o       (axi_arid_o),
    .axi_rvalid_i     (axi_rvalid_i),
    .axi_rready_o     (axi_rready_o),
    .axi_rdata_i      (axi_rdata_i),
    .axi_rresp_i      (axi_rresp_i),
    .axi_rlast_i      (axi_rlast_i),
    .axi_rid_i        (axi_rid_i),
    .rd_err_o         (rd_err_o),
    .state_dbg_o      (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ic_v;
    logic        lsu_v;
    logic [31:0] ic_addr;
    logic [7:0]  ic_len;
    logic [31:0] lsu_addr;
    logic [2:0]  lsu_size;
    int          ar_delay;
    int          err_beat;
    logic [1:0]  err_resp;
    logic [3:0]  err_rid_x;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [3:0]  exp_id;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (axi_arvalid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL ar_timeout: arvalid=0 for 20 cycles, required 1");
    end
  endtask

  task automatic check_ar(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [3:0] id);
    chk("araddr", axi_araddr_o, addr);
    chk("arlen", axi_arlen_o, len);
    chk("arsize", axi_arsize_o, size);
    chk("arburst", axi_arburst_o, 2'b01);
    chk("arid", axi_arid_o, id);
  endtask

  // Entered at a negedge with arvalid seen; leaves one cycle into DATA.
  // A stray R beat is offered while waiting to show it is not acknowledged.
  task automatic do_ar(input int delay, input logic [31:0] addr);
    axi_rvalid_i = 1'b1;
    axi_rlast_i  = 1'b1;
    for (int d = 0; d < delay; d++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("ar_hold_valid", axi_arvalid_o, 1'b1);
      chk("ar_hold_addr", axi_araddr_o, addr);
      chk("no_rready_in_addr", axi_rready_o, 1'b0);
      chk("no_fwd_in_addr", {icache_r_ready_o, lsu_r_ready_o}, 2'b00);
    end
    @(posedge clock); #1;
    axi_rvalid_i  = 1'b0;
    axi_rlast_i   = 1'b0;
    axi_arready_i = 1'b1;
    @(negedge clock);
    chk("ar_valid_at_hs", axi_arvalid_o, 1'b1);
    @(posedge clock); #1;
    axi_arready_i = 1'b0;
  endtask

  task automatic do_beats(input logic [7:0] len, input logic lsu, input logic [3:0] id,
                          input int err_beat, input logic [1:0] err_resp,
                          input logic [3:0] err_rid_x);
    logic [31:0] d;
    logic        e;
    logic        lst;
    for (int i = 0; i <= int'(len); i++) begin
      d            = $urandom;
      lst          = (i == int'(len));
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = d;
      axi_rlast_i  = lst;
      axi_rresp_i  = (i == err_beat) ? err_resp : 2'b00;
      axi_rid_i    = (i == err_beat) ? (id ^ err_rid_x) : id;
      e            = (i == err_beat) && ((err_resp != 2'b00) || (err_rid_x != 4'd0));
      @(negedge clock);
      chk("rready_in_data", axi_rready_o, 1'b1);
      if (lsu) begin
        chk("lsu_ready", lsu_r_ready_o, 1'b1);
        chk("lsu_data", lsu_r_data_o, d);
        chk("lsu_last", lsu_r_last_o, lst);
        chk("icache_idle", {icache_r_ready_o, icache_r_last_o, icache_r_data_o}, '0);
      end else begin
        chk("icache_ready", icache_r_ready_o, 1'b1);
        chk("icache_data", icache_r_data_o, d);
        chk("icache_last", icache_r_last_o, lst);
        chk("lsu_idle", {lsu_r_ready_o, lsu_r_last_o, lsu_r_data_o}, '0);
      end
      @(posedge clock); #1;
      chk("rd_err", rd_err_o, e);
    end
    axi_rvalid_i = 1'b0;
    axi_rlast_i  = 1'b0;
    axi_rresp_i  = 2'b00;
    chk("idle_after_rlast", state_dbg_o, S_IDLE);
    @(posedge clock); #1;
    chk("rd_err_pulse_end", rd_err_o, 1'b0);
  endtask

  task automatic run_txn(input vec_t v);
    bit ok;
    icache_r_valid_i = v.ic_v;
    icache_r_addr_i  = v.ic_addr;
    icache_r_len_i   = v.ic_len;
    lsu_r_valid_i    = v.lsu_v;
    lsu_r_addr_i     = v.lsu_addr;
    lsu_r_size_i     = v.lsu_size;
    wait_arvalid(ok);
    if (!ok) return;
    icache_r_valid_i = 1'b0;
    lsu_r_valid_i    = 1'b0;
    check_ar(v.exp_addr, v.exp_len, v.exp_size, v.exp_id);
    do_ar(v.ar_delay, v.exp_addr);
    chk("state_data", state_dbg_o, S_DATA);
    do_beats(v.exp_len, v.exp_lsu, v.exp_id, v.err_beat, v.err_resp, v.err_rid_x);
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    bit ok;
    logic [31:0] d;

    // Last grant before the table is LSU (the ordering sequence ends on it).
    vecs[0] = '{1'b1, 1'b1, 32'h3000_0040, 8'd3, 32'h8000_0008, 3'd2, 0, 1, 2'b10, 4'h0,
                1'b0, 32'h3000_0040, 8'd3, 3'd2, 4'd0};
    vecs[1] = '{1'b1, 1'b1, 32'h3000_0050, 8'd3, 32'h8000_000C, 3'd1, 1, -1, 2'b00, 4'h0,
                1'b1, 32'h8000_000C, 8'd0, 3'd1, 4'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h3000_0060, 8'd3, 32'h8000_0101, 3'd0, 3, 0, 2'b00, 4'h2,
                1'b1, 32'h8000_0101, 8'd0, 3'd0, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h3000_0070, 8'd3, 32'h8000_0000, 3'd2, 0, 3, 2'b11, 4'h0,
                1'b0, 32'h3000_0070, 8'd3, 3'd2, 4'd0};
    vecs[4] = '{1'b1, 1'b1, 32'h3000_0080, 8'd3, 32'h8000_0202, 3'd1, 2, -1, 2'b00, 4'h0,
                1'b1, 32'h8000_0202, 8'd0, 3'd1, 4'd1};
    vecs[5] = '{1'b1, 1'b0, 32'h3000_0090, 8'd7, 32'h8000_0000, 3'd2, 1, -1, 2'b00, 4'h0,
                1'b0, 32'h3000_0090, 8'd7, 3'd2, 4'd0};

    reset            = 1'b0;
    icache_r_valid_i = 1'b0;
    icache_r_addr_i  = '0;
    icache_r_len_i   = '0;
    lsu_r_valid_i    = 1'b0;
    lsu_r_addr_i     = '0;
    lsu_r_size_i     = '0;
    axi_arready_i    = 1'b0;
    axi_rvalid_i     = 1'b0;
    axi_rdata_i      = '0;
    axi_rresp_i      = '0;
    axi_rlast_i      = 1'b0;
    axi_rid_i        = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_state", state_dbg_o, S_IDLE);
    chk("rst_arvalid", axi_arvalid_o, 1'b0);
    chk("rst_rready", axi_rready_o, 1'b0);
    chk("rst_rd_err", rd_err_o, 1'b0);
    chk("rst_ar_fields", {axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arid_o}, '0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Simultaneous requests after reset: Icache first, then LSU.
    icache_r_valid_i = 1'b1;
    icache_r_addr_i  = 32'h3000_0010;
    icache_r_len_i   = 8'd3;
    lsu_r_valid_i    = 1'b1;
    lsu_r_addr_i     = 32'h8000_0004;
    lsu_r_size_i     = 3'd2;
    wait_arvalid(ok);
    if (ok) begin
      icache_r_valid_i = 1'b0;
      check_ar(32'h3000_0010, 8'd3, 3'd2, 4'd0);
      do_ar(2, 32'h3000_0010);
      do_beats(8'd3, 1'b0, 4'd0, -1, 2'b00, 4'h0);
      wait_arvalid(ok);
      if (ok) begin
        lsu_r_valid_i = 1'b0;
        check_ar(32'h8000_0004, 8'd0, 3'd2, 4'd1);
        do_ar(0, 32'h8000_0004);
        do_beats(8'd0, 1'b1, 4'd1, -1, 2'b00, 4'h0);
      end
    end
    icache_r_valid_i = 1'b0;
    lsu_r_valid_i    = 1'b0;

    // Table-driven arbitration / forwarding / error vectors
    for (int k = 0; k < 6; k++) begin
      run_txn(vecs[k]);
    end

    // LSU in flight, Icache raises valid and must wait.
    lsu_r_valid_i = 1'b1;
    lsu_r_addr_i  = 32'h8000_0010;
    lsu_r_size_i  = 3'd0;
    wait_arvalid(ok);
    if (ok) begin
      check_ar(32'h8000_0010, 8'd0, 3'd0, 4'd1);
      do_ar(1, 32'h8000_0010);
      icache_r_valid_i = 1'b1;
      icache_r_addr_i  = 32'h3000_0100;
      icache_r_len_i   = 8'd3;
      @(negedge clock);
      chk("ic_blocked_ready", icache_r_ready_o, 1'b0);
      chk("ic_blocked_ar", axi_arvalid_o, 1'b0);
      @(posedge clock); #1;
      d            = 32'hCAFE_0001;
      axi_rvalid_i = 1'b1;
      axi_rlast_i  = 1'b1;
      axi_rdata_i  = d;
      axi_rid_i    = 4'd1;
      @(negedge clock);
      chk("lsu_last_pulse", lsu_r_last_o, 1'b1);
      chk("lsu_beat_data", lsu_r_data_o, d);
      chk("ic_no_beat", icache_r_ready_o, 1'b0);
      @(posedge clock); #1;
      axi_rvalid_i  = 1'b0;
      axi_rlast_i   = 1'b0;
      lsu_r_valid_i = 1'b0;
      @(negedge clock);
      chk("lsu_last_once", lsu_r_last_o, 1'b0);
      chk("ic_ar_not_early", axi_arvalid_o, 1'b0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("ic_ar_two_after", axi_arvalid_o, 1'b1);
      icache_r_valid_i = 1'b0;
      check_ar(32'h3000_0100, 8'd3, 3'd2, 4'd0);
      do_ar(0, 32'h3000_0100);
      do_beats(8'd3, 1'b0, 4'd0, -1, 2'b00, 4'h0);
    end
    lsu_r_valid_i    = 1'b0;
    icache_r_valid_i = 1'b0;

    // Reset during beat 2 of 4, then a fresh Icache burst.
    icache_r_valid_i = 1'b1;
    icache_r_addr_i  = 32'h3000_0200;
    icache_r_len_i   = 8'd3;
    wait_arvalid(ok);
    if (ok) begin
      do_ar(0, 32'h3000_0200);
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = 32'h1111_0000;
      axi_rid_i    = 4'd0;
      @(negedge clock);
      chk("pre_rst_beat", icache_r_ready_o, 1'b1);
      @(posedge clock); #1;
      axi_rdata_i      = 32'h1111_0001;
      reset            = 1'b0;
      icache_r_valid_i = 1'b0;
      @(negedge clock);
      chk("rst_cycle_fwd", {icache_r_ready_o, icache_r_last_o, lsu_r_ready_o, lsu_r_last_o}, 4'b0);
      chk("rst_cycle_rready", axi_rready_o, 1'b0);
      @(posedge clock); #1;
      reset        = 1'b1;
      axi_rvalid_i = 1'b0;
      @(negedge clock);
      chk("post_rst_state", state_dbg_o, S_IDLE);
      chk("post_rst_arvalid", axi_arvalid_o, 1'b0);
      chk("post_rst_araddr", axi_araddr_o, 32'h0);
      chk("post_rst_rd_err", rd_err_o, 1'b0);
      @(posedge clock); #1;
    end
    run_txn('{1'b1, 1'b0, 32'h3000_0300, 8'd3, 32'h0, 3'd2, 1, -1, 2'b00, 4'h0,
              1'b0, 32'h3000_0300, 8'd3, 3'd2, 4'd0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
